// File: rtl/icache_pkg.sv
// Shared types for the instruction cache and its bus neighbours.
// Holds the ibus (fetch-side) and cbus (memory-side) request/response structs,
// the cbus size/length/burst encodings, the icache FSM state type, the default
// geometry (ICACHE_SETS, ICACHE_LINE_WORDS) and a 32-bit half-word selector.
package icache_pkg;

    localparam int ICACHE_SETS       = 16;
    localparam int ICACHE_LINE_WORDS = 8;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    // Burst length is encoded as beats minus one.
    typedef enum logic [3:0] {
        MLEN1  = 4'd0,
        MLEN2  = 4'd1,
        MLEN4  = 4'd3,
        MLEN8  = 4'd7,
        MLEN16 = 4'd15
    } mlen_t;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'd0,
        AXI_BURST_INCR  = 2'd1,
        AXI_BURST_WRAP  = 2'd2
    } axi_burst_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        msize_t      size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        mlen_t       len;
        axi_burst_t  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    typedef enum logic [1:0] {
        ICACHE_IDLE     = 2'd0,
        ICACHE_REFILL   = 2'd1,
        ICACHE_UNCACHED = 2'd2
    } icache_state_t;

    // Pick the upper or lower 32-bit instruction slot of a 64-bit word.
    function automatic logic [31:0] half_select(input logic [63:0] word, input logic upper);
        return upper ? word[63:32] : word[31:0];
    endfunction

endpackage

// File: rtl/icache_array.sv
// Flop-based storage for the icache: per-line valid bits, tags and data words.
// Ports: clk, reset (async active-low, clears valid bits only);
//   rd_index/rd_word -> rd_valid/rd_tag/rd_data (combinational read);
//   word_we/wr_index/wr_word/wr_data (one 64-bit word write);
//   tag_we/tag_index/tag_data/set_valid (tag write, optional validate);
//   clear_all (flash-clear of every valid bit, wins over set_valid).
module icache_array
    import icache_pkg::*;
#(
    parameter int SETS       = ICACHE_SETS,
    parameter int LINE_WORDS = ICACHE_LINE_WORDS,
    parameter int IDX_W      = 4,
    parameter int WORD_W     = 3,
    parameter int TAG_W      = 54
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_index,
    input  logic [WORD_W-1:0] rd_word,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [63:0]       rd_data,
    input  logic              word_we,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [WORD_W-1:0] wr_word,
    input  logic [63:0]       wr_data,
    input  logic              tag_we,
    input  logic [IDX_W-1:0]  tag_index,
    input  logic [TAG_W-1:0]  tag_data,
    input  logic              set_valid,
    input  logic              clear_all
);

    logic [SETS-1:0]  valid_r;
    logic [TAG_W-1:0] tag_r  [SETS];
    logic [63:0]      data_r [SETS][LINE_WORDS];

    // Valid bits: the only reset state in the array; a flash clear beats a set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r <= '0;
        end else if (clear_all) begin
            valid_r <= '0;
        end else if (tag_we && set_valid) begin
            valid_r[tag_index] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag storage, written once per completed refill.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_r[tag_index] <= tag_data;
        end
    end

    // Data storage, one word per refill beat.
    always_ff @(posedge clk) begin
        if (word_we) begin
            data_r[wr_index][wr_word] <= wr_data;
        end
    end

    assign rd_valid = valid_r[rd_index];
    assign rd_tag   = tag_r[rd_index];
    assign rd_data  = data_r[rd_index][rd_word];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache.
// Cached space (addr[31]=1) hits answer in the request cycle; misses run an
// 8-beat INCR line refill on cbus. Uncached space is a single-beat read whose
// data is forwarded on the ready cycle. flush invalidates every line; a flush
// seen while a cbus transaction is open is deferred until it completes.
// Ports: clk, reset (async active-low), flush, ireq/iresp (fetch side),
//   creq/cresp (memory side).
module icache
    import icache_pkg::*;
#(
    parameter int SETS       = ICACHE_SETS,
    parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    output cbus_req_t  creq,
    input  cbus_resp_t cresp
);

    localparam int IDX_W  = $clog2(SETS);
    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = WORD_W + 3;
    localparam int TAG_W  = 64 - OFF_W - IDX_W;

    icache_state_t     state_r, state_nx;
    logic [WORD_W-1:0] cnt_r;
    logic              flush_pending_r;
    logic [63:0]       addr_r;

    logic              rd_valid_s;
    logic [TAG_W-1:0]  rd_tag_s;
    logic [63:0]       rd_data_s;
    logic              hit_s;
    logic              start_refill_s, start_uncached_s;
    logic              beat_we_s, line_done_s, unc_done_s;
    logic              flush_eff_s, clear_all_s, set_valid_s;

    assign hit_s       = rd_valid_s && (rd_tag_s == ireq.addr[63 -: TAG_W]);
    // A flush arriving on the completing beat counts as already pending.
    assign flush_eff_s = flush_pending_r || flush;
    assign clear_all_s = ((state_r == ICACHE_IDLE) && flush) ||
                         ((line_done_s || unc_done_s) && flush_eff_s);
    assign set_valid_s = !flush_eff_s;

    icache_array #(
        .SETS      (SETS),
        .LINE_WORDS(LINE_WORDS),
        .IDX_W     (IDX_W),
        .WORD_W    (WORD_W),
        .TAG_W     (TAG_W)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .rd_index (ireq.addr[OFF_W +: IDX_W]),
        .rd_word  (ireq.addr[3 +: WORD_W]),
        .rd_valid (rd_valid_s),
        .rd_tag   (rd_tag_s),
        .rd_data  (rd_data_s),
        .word_we  (beat_we_s),
        .wr_index (addr_r[OFF_W +: IDX_W]),
        .wr_word  (cnt_r),
        .wr_data  (cresp.data),
        .tag_we   (line_done_s),
        .tag_index(addr_r[OFF_W +: IDX_W]),
        .tag_data (addr_r[63 -: TAG_W]),
        .set_valid(set_valid_s),
        .clear_all(clear_all_s)
    );

    // Next-state, ibus response and cbus request decode.
    always_comb begin
        state_nx         = state_r;
        iresp            = '0;
        creq             = '0;
        start_refill_s   = 1'b0;
        start_uncached_s = 1'b0;
        beat_we_s        = 1'b0;
        line_done_s      = 1'b0;
        unc_done_s       = 1'b0;
        case (state_r)
            ICACHE_IDLE: begin
                if (ireq.valid) begin
                    if (ireq.addr[31]) begin
                        if (hit_s) begin
                            iresp.addr_ok = 1'b1;
                            iresp.data_ok = 1'b1;
                            iresp.data    = half_select(rd_data_s, ireq.addr[2]);
                        end else begin
                            start_refill_s = 1'b1;
                            state_nx       = ICACHE_REFILL;
                        end
                    end else begin
                        start_uncached_s = 1'b1;
                        state_nx         = ICACHE_UNCACHED;
                    end
                end else begin
                    state_nx = ICACHE_IDLE;
                end
            end
            ICACHE_REFILL: begin
                creq.valid = 1'b1;
                creq.size  = MSIZE8;
                creq.addr  = addr_r;
                creq.len   = MLEN8;
                creq.burst = AXI_BURST_INCR;
                if (cresp.ready) begin
                    beat_we_s = 1'b1;
                    if (cresp.last) begin
                        line_done_s = 1'b1;
                        state_nx    = ICACHE_IDLE;
                    end else begin
                        state_nx = ICACHE_REFILL;
                    end
                end else begin
                    state_nx = ICACHE_REFILL;
                end
            end
            ICACHE_UNCACHED: begin
                creq.valid = 1'b1;
                creq.size  = MSIZE4;
                creq.addr  = addr_r;
                creq.len   = MLEN1;
                creq.burst = AXI_BURST_FIXED;
                if (cresp.ready) begin
                    unc_done_s = 1'b1;
                    state_nx   = ICACHE_IDLE;
                    // Only answer a requester still asking for this address.
                    if (ireq.valid && (ireq.addr == addr_r)) begin
                        iresp.addr_ok = 1'b1;
                        iresp.data_ok = 1'b1;
                        iresp.data    = half_select(cresp.data, addr_r[2]);
                    end else begin
                        iresp = '0;
                    end
                end else begin
                    state_nx = ICACHE_UNCACHED;
                end
            end
            default: begin
                state_nx = ICACHE_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ICACHE_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Latched transaction address and refill beat counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_r <= 64'h0;
            cnt_r  <= '0;
        end else if (start_refill_s) begin
            addr_r <= {ireq.addr[63:OFF_W], {OFF_W{1'b0}}};
            cnt_r  <= '0;
        end else if (start_uncached_s) begin
            addr_r <= ireq.addr;
        end else if (beat_we_s) begin
            cnt_r <= cnt_r + WORD_W'(1);
        end
    end

    // Deferred flush: remembered while busy, consumed when returning to IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush_pending_r <= 1'b0;
        end else if (line_done_s || unc_done_s) begin
            flush_pending_r <= 1'b0;
        end else if (flush && (state_r != ICACHE_IDLE)) begin
            flush_pending_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Bench for icache: random and directed fetches, a cbus memory responder,
// a scoreboard queue filled at issue and drained by a monitor on data_ok, and
// a set/tag/valid reference model predicting how many cbus reads each fetch costs.
module tb_icache;
    import icache_pkg::*;

    logic       clk;
    logic       reset;
    logic       flush;
    ibus_req_t  ireq;
    ibus_resp_t iresp;
    cbus_req_t  creq;
    cbus_resp_t cresp;

    int errors = 0;
    int checks = 0;

    logic [31:0] sb[$];
    int          txn_cnt;
    bit          in_txn;
    int          beat;
    bit          prev_ready, prev_last;
    bit          full_rate;
    cbus_req_t   txn_req;
    logic [63:0] cur_addr;

    bit          mv[16];
    logic [53:0] mt[16];

    icache dut (
        .clk  (clk),
        .reset(reset),
        .flush(flush),
        .ireq (ireq),
        .iresp(iresp),
        .creq (creq),
        .cresp(cresp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        return {a[31:0] ^ 32'hA5C3_0000 ^ a[63:32], a[31:0] + 32'h1357_9BDF};
    endfunction

    function automatic logic [31:0] exp_data(input logic [63:0] a);
        logic [63:0] w;
        w = mem_word({a[63:3], 3'b000});
        return a[2] ? w[63:32] : w[31:0];
    endfunction

    // Reference model: returns number of cbus reads the fetch should cause.
    function automatic int model_access(input logic [63:0] a);
        int idx;
        idx = int'(a[9:6]);
        if (!a[31]) return 1;
        if (mv[idx] && mt[idx] == a[63:10]) return 0;
        mv[idx] = 1'b1;
        mt[idx] = a[63:10];
        return 1;
    endfunction

    function automatic void model_flush();
        for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    endfunction

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // cbus memory responder with random or back-to-back ready.
    initial begin
        cresp = '0; in_txn = 1'b0; beat = 0; prev_ready = 1'b0; prev_last = 1'b0; txn_cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (!reset) begin
                in_txn = 1'b0; beat = 0; prev_ready = 1'b0; prev_last = 1'b0; cresp = '0;
            end else begin
                if (in_txn && prev_ready) begin
                    if (prev_last) in_txn = 1'b0;
                    else beat++;
                end
                if (in_txn) begin
                    checks++;
                    if (creq !== txn_req) begin
                        errors++;
                        $display("FAIL creq_stable: got %h expected %h", creq, txn_req);
                    end
                end else if (creq.valid) begin
                    bit ok;
                    txn_req = creq; in_txn = 1'b1; beat = 0; txn_cnt++;
                    if (cur_addr[31])
                        ok = creq.is_write == 1'b0 && creq.size == MSIZE8 && creq.len == MLEN8 &&
                             creq.burst == AXI_BURST_INCR && creq.addr == {cur_addr[63:6], 6'b0} &&
                             creq.strobe == 8'h00 && creq.data == 64'h0;
                    else
                        ok = creq.is_write == 1'b0 && creq.size == MSIZE4 && creq.len == MLEN1 &&
                             creq.burst == AXI_BURST_FIXED && creq.addr == cur_addr;
                    checks++;
                    if (!ok) begin
                        errors++;
                        $display("FAIL creq_fields: got addr=%h size=%0d len=%0d burst=%0d required addr=%h", creq.addr, creq.size, creq.len, creq.burst, cur_addr);
                    end
                end
                if (in_txn) begin
                    cresp.ready = full_rate ? 1'b1 : ($urandom_range(0, 2) != 0);
                    cresp.last  = cresp.ready && (beat == int'(txn_req.len));
                    cresp.data  = mem_word({txn_req.addr[63:3], 3'b000} + 64'(beat) * 64'd8);
                end else begin
                    cresp = '0;
                end
                prev_ready = cresp.ready;
                prev_last  = cresp.last;
            end
        end
    end

    // Monitor: pops the scoreboard on every response; otherwise iresp must be zero.
    initial begin
        forever begin
            @(negedge clk);
            if (iresp.data_ok) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected: got data=%h with nothing outstanding", iresp.data);
                end else begin
                    logic [31:0] e;
                    e = sb.pop_front();
                    if (iresp.data !== e || iresp.addr_ok !== 1'b1) begin
                        errors++;
                        $display("FAIL resp_data: got data=%h addr_ok=%b required data=%h addr_ok=1", iresp.data, iresp.addr_ok, e);
                    end
                end
            end else begin
                checks++;
                if (iresp !== '0) begin
                    errors++;
                    $display("FAIL resp_idle: got %h required 0", iresp);
                end
            end
        end
    end

    // Issue one fetch (called at posedge+1), hold until data_ok, return cycles and cbus reads.
    task automatic do_req(input logic [63:0] a, output int lat, output int ntx);
        int t0;
        bit got;
        t0 = txn_cnt; got = 1'b0; lat = 0;
        cur_addr = a;
        sb.push_back(exp_data(a));
        ireq.valid = 1'b1;
        ireq.addr  = a;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (iresp.data_ok) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL timeout: addr=%h got no data_ok required one", a);
            if (sb.size() > 0) void'(sb.pop_back());
        end
        @(posedge clk); #1;
        ireq.valid = 1'b0;
        ntx = txn_cnt - t0;
    endtask

    task automatic check_req(input string name, input logic [63:0] a);
        int e, lat, ntx;
        e = model_access(a);
        do_req(a, lat, ntx);
        check_int({name, "_txns"}, ntx, e);
        if (e == 0) check_int({name, "_lat"}, lat, 0);
        else if (full_rate) check_int({name, "_lat"}, lat, a[31] ? 9 : 1);
    endtask

    task automatic flush_pulse();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(posedge clk); #2;
            if (in_txn && beat == 4) begin
                flush = 1'b1;
                @(posedge clk); #2;
                flush = 1'b0;
                done = 1'b1;
            end
        end
        check_int("flush_window", int'(done), 1);
    endtask

    initial begin
        int lat, ntx, found;
        logic [63:0] a;
        logic [63:0] bases[3];
        bases[0] = 64'h0000_0000_8000_0000;
        bases[1] = 64'h0000_0000_8000_0400;
        bases[2] = 64'h0000_0001_8000_0000;
        reset = 1'b0; flush = 1'b0; ireq = '0; full_rate = 1'b1; cur_addr = 64'h0;
        model_flush();
        repeat (3) @(posedge clk);
        #1;
        check_int("reset_creq_valid", int'(creq.valid), 0);
        check_int("reset_iresp", int'(iresp != '0), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        check_req("cold_miss", 64'h8000_0040);
        check_req("follow_hit", 64'h8000_0044);

        check_req("fill0", 64'h8000_0000);
        check_req("conflict", 64'h8000_0400);
        check_req("refetch0", 64'h8000_0000);

        check_req("unc1", 64'h1000_0004);
        check_req("unc2", 64'h1000_0004);

        check_req("b2b_fill", 64'h8000_0880);
        for (int i = 0; i < 8; i++) check_req("b2b_hit", 64'h8000_0880 + 64'(i) * 64'd4);

        check_req("flush_pre", 64'h8000_0300);
        fork
            do_req(64'h8000_0340, lat, ntx);
            flush_pulse();
        join
        check_int("flush_refills", ntx, 2);
        model_flush();
        void'(model_access(64'h8000_0340));
        check_req("flush_old_line", 64'h8000_0300);
        check_req("flush_line_hit", 64'h8000_0344);

        check_req("pre_rst_a", 64'h8000_0080);
        check_req("pre_rst_b", 64'h8000_0100);
        cur_addr = 64'h8000_0500;
        ireq.valid = 1'b1; ireq.addr = 64'h8000_0500;
        found = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #2;
            if (in_txn && beat >= 3) begin
                found = 1;
                break;
            end
        end
        check_int("reset_window", found, 1);
        #1;
        reset = 1'b0;
        #1;
        check_int("midrst_creq_valid", int'(creq.valid), 0);
        check_int("midrst_iresp", int'(iresp != '0), 0);
        ireq = '0;
        repeat (2) @(posedge clk);
        #4;
        reset = 1'b1;
        @(posedge clk); #1;
        model_flush();
        check_req("post_rst_a", 64'h8000_0080);
        check_req("post_rst_b", 64'h8000_0100);

        full_rate = 1'b0;
        for (int i = 0; i < 60; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                flush = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
                model_flush();
            end else if (r <= 2) begin
                a = 64'h0000_0000_2000_0000 + 64'($urandom_range(0, 255)) * 64'd4;
                check_req("rand_unc", a);
            end else begin
                a = bases[$urandom_range(0, 2)] + 64'($urandom_range(0, 3)) * 64'd64 +
                    64'($urandom_range(0, 7)) * 64'd8 + 64'($urandom_range(0, 1)) * 64'd4;
                check_req("rand_cached", a);
            end
        end
        check_int("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
